// File: rtl/branch_predictor_btb_pkg.sv
// ============================================================================
// Module      : branch_predictor_btb_pkg
// Description : Shared constants, types and helpers for the BTB predictor.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package branch_predictor_btb_pkg;

  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    SAT_HOLD = 2'd0,
    SAT_INC  = 2'd1,
    SAT_DEC  = 2'd2,
    SAT_LOAD = 2'd3
  } sat_op_e;

  // Word-aligned PCs: two low bits never reach the index or the tag.
  function automatic int btb_idx_w(input int entries);
    return $clog2(entries);
  endfunction

  function automatic int btb_tag_w(input int entries);
    return 30 - $clog2(entries);
  endfunction

  function automatic logic [3:0] ctr_weak_taken(input int w);
    return 4'(1 << (w - 1));
  endfunction

  function automatic logic [3:0] ctr_weak_not_taken(input int w);
    return 4'((1 << (w - 1)) - 1);
  endfunction

  function automatic logic [ADDR_W-1:0] sat_inc32(input logic [ADDR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/branch_predictor_btb_if.sv
// ============================================================================
// Module      : branch_predictor_btb_if
// Description : Lookup, resolve/update and statistics signals of the BTB.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface branch_predictor_btb_if
  import branch_predictor_btb_pkg::*;
();

  logic [ADDR_W-1:0] pc_i;
  logic              lookup_en_i;
  logic              pre_branch_flag_o;
  logic [ADDR_W-1:0] pre_branch_target_address_o;
  logic              pre_take_or_not_o;
  logic              pre_sel_o;
  logic              id_is_branch_i;
  logic              id_take_or_not_i;
  logic              id_pre_true_i;
  logic              id_sel_i;
  logic [ADDR_W-1:0] id_pc_i;
  logic [ADDR_W-1:0] id_target_i;
  logic              flush_i;
  logic [31:0]       mispredict_cnt_o;
  logic [31:0]       branch_cnt_o;

  modport slave (
    input  pc_i, lookup_en_i,
    input  id_is_branch_i, id_take_or_not_i, id_pre_true_i, id_sel_i,
    input  id_pc_i, id_target_i, flush_i,
    output pre_branch_flag_o, pre_branch_target_address_o,
    output pre_take_or_not_o, pre_sel_o,
    output mispredict_cnt_o, branch_cnt_o
  );

  modport master (
    output pc_i, lookup_en_i,
    output id_is_branch_i, id_take_or_not_i, id_pre_true_i, id_sel_i,
    output id_pc_i, id_target_i, flush_i,
    input  pre_branch_flag_o, pre_branch_target_address_o,
    input  pre_take_or_not_o, pre_sel_o,
    input  mispredict_cnt_o, branch_cnt_o
  );

endinterface

`default_nettype wire

// File: rtl/branch_predictor_btb_sat_counter.sv
// ============================================================================
// Module      : sat_counter
// Description : Combinational next value of a saturating up/down/load counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter
  import branch_predictor_btb_pkg::*;
#(
  parameter int W = 2
) (
  input  sat_op_e        i_op,
  input  logic [W-1:0]   i_cnt,
  input  logic [W-1:0]   i_load_val,
  output logic [W-1:0]   o_cnt
);

  always_comb begin
    o_cnt = i_cnt;
    case (i_op)
      SAT_INC:  if (!(&i_cnt)) o_cnt = i_cnt + 1'b1;
      SAT_DEC:  if (|i_cnt)    o_cnt = i_cnt - 1'b1;
      SAT_LOAD: o_cnt = i_load_val;
      default:  o_cnt = i_cnt;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/branch_predictor_btb.sv
// ============================================================================
// Module      : branch_predictor_btb
// Description : Direct-mapped register-based BTB with saturating direction
//               counters, zero-latency lookup and resolve-time update.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predictor_btb
  import branch_predictor_btb_pkg::*;
#(
  parameter int ENTRIES = 64,
  parameter int CTR_W   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_predictor_btb_if.slave bus
);

  localparam int IDX_W = btb_idx_w(ENTRIES);
  localparam int TAG_W = btb_tag_w(ENTRIES);
  localparam logic [CTR_W-1:0] C_CTR_WT  = CTR_W'(ctr_weak_taken(CTR_W));
  localparam logic [CTR_W-1:0] C_CTR_WNT = CTR_W'(ctr_weak_not_taken(CTR_W));

  generate
    if ((ENTRIES < 4) || (ENTRIES > 1024) || ((ENTRIES & (ENTRIES - 1)) != 0)) begin : g_bad_entries
      $error("ENTRIES must be a power of two in 4..1024");
    end
    if ((CTR_W < 1) || (CTR_W > 4)) begin : g_bad_ctr_w
      $error("CTR_W must be in 1..4");
    end
  endgenerate

  logic                  r_valid  [ENTRIES];
  logic [TAG_W-1:0]      r_tag    [ENTRIES];
  logic [ADDR_W-1:0]     r_target [ENTRIES];
  logic [CTR_W-1:0]      r_ctr    [ENTRIES];
  logic [31:0]           r_branch_cnt;
  logic [31:0]           r_mispredict_cnt;

  logic [IDX_W-1:0]      w_lk_idx;
  logic [TAG_W-1:0]      w_lk_tag;
  logic                  w_hit;
  logic                  w_pred_taken;
  logic [IDX_W-1:0]      w_up_idx;
  logic [TAG_W-1:0]      w_up_tag;
  logic                  w_up_match;
  logic                  w_write;
  sat_op_e               w_sat_op;
  logic [CTR_W-1:0]      w_ctr_next;
  logic                  w_unused;

  assign w_lk_idx = bus.pc_i[IDX_W+1:2];
  assign w_lk_tag = bus.pc_i[ADDR_W-1:IDX_W+2];

  // Reset gating keeps the fetch stage from redirecting on stale entries.
  assign w_hit        = bus.lookup_en_i & ~rst & r_valid[w_lk_idx] &
                        (r_tag[w_lk_idx] == w_lk_tag);
  assign w_pred_taken = w_hit & r_ctr[w_lk_idx][CTR_W-1];

  assign bus.pre_sel_o                   = w_hit;
  assign bus.pre_take_or_not_o           = w_pred_taken;
  assign bus.pre_branch_flag_o           = w_pred_taken;
  assign bus.pre_branch_target_address_o = w_hit ? r_target[w_lk_idx] : '0;

  assign w_up_idx   = bus.id_pc_i[IDX_W+1:2];
  assign w_up_tag   = bus.id_pc_i[ADDR_W-1:IDX_W+2];
  assign w_up_match = r_valid[w_up_idx] & (r_tag[w_up_idx] == w_up_tag);

  // A not-taken branch that misses is never worth a table slot.
  assign w_write = bus.id_is_branch_i & ~bus.flush_i &
                   (w_up_match | bus.id_take_or_not_i);

  always_comb begin
    w_sat_op = SAT_HOLD;
    if (w_up_match)
      w_sat_op = bus.id_take_or_not_i ? SAT_INC : SAT_DEC;
    else if (bus.id_take_or_not_i)
      w_sat_op = SAT_LOAD;
  end

  sat_counter #(
    .W (CTR_W)
  ) u_dir_ctr (
    .i_op       (w_sat_op),
    .i_cnt      (r_ctr[w_up_idx]),
    .i_load_val (C_CTR_WT),
    .o_cnt      (w_ctr_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= C_CTR_WNT;
      end
      r_branch_cnt     <= '0;
      r_mispredict_cnt <= '0;
    end else begin
      if (bus.flush_i) begin
        for (int i = 0; i < ENTRIES; i++) r_valid[i] <= 1'b0;
      end else if (w_write) begin
        r_valid[w_up_idx] <= 1'b1;
        r_ctr[w_up_idx]   <= w_ctr_next;
      end
      if (bus.id_is_branch_i) begin
        r_branch_cnt <= sat_inc32(r_branch_cnt);
        if (!bus.id_pre_true_i) r_mispredict_cnt <= sat_inc32(r_mispredict_cnt);
      end
    end
  end

  // Tag and target carry no reset; validity alone qualifies them.
  always_ff @(posedge clk) begin
    if (!rst && w_write && bus.id_take_or_not_i) begin
      r_tag[w_up_idx]    <= w_up_tag;
      r_target[w_up_idx] <= bus.id_target_i;
    end
  end

  assign bus.branch_cnt_o     = r_branch_cnt;
  assign bus.mispredict_cnt_o = r_mispredict_cnt;

  assign w_unused = ^{bus.pc_i[1:0], bus.id_pc_i[1:0], bus.id_sel_i};

endmodule

`default_nettype wire

// File: doc/branch_predictor_btb.md
BRANCH_PREDICTOR_BTB -- requirements
Module: branch_predictor_btb

Interface
REQ-001 Parameter ENTRIES, default 64, number of BTB entries; SHALL be a power of two, range 4..1024.
REQ-002 Parameter CTR_W, default 2, width of each saturating direction counter; SHALL be in the range 1..4.
REQ-003 Derived constants SHALL be IDX_W = log2(ENTRIES) and TAG_W = 30 - IDX_W.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 pc_i  in  32  fetch PC being looked up (same cycle as instruction fetch).
REQ-007 lookup_en_i  in  1  lookup qualifier (instruction chip enable).
REQ-008 pre_branch_flag_o  out  1  redirect fetch to the predicted target.
REQ-009 pre_branch_target_address_o  out  32  predicted target.
REQ-010 pre_take_or_not_o  out  1  predicted direction (counter MSB).
REQ-011 pre_sel_o  out  1  BTB hit on lookup.
REQ-012 id_is_branch_i  in  1  resolved conditional branch or jump in ID; update strobe.
REQ-013 id_take_or_not_i  in  1  actual outcome.
REQ-014 id_pre_true_i  in  1  prediction was correct.
REQ-015 id_sel_i  in  1  the lookup for this branch hit.
REQ-016 id_pc_i  in  32  branch PC.
REQ-017 id_target_i  in  32  resolved target.
REQ-018 flush_i  in  1  invalidate every entry.
REQ-019 mispredict_cnt_o  out  32  saturating mispredict counter.
REQ-020 branch_cnt_o  out  32  saturating resolved-branch counter.

Function
REQ-021 Index SHALL be pc[IDX_W+1:2] and tag SHALL be pc[31:IDX_W+2]; pc[1:0] is ignored.
REQ-022 Each entry SHALL hold valid, tag, target[31:0] and ctr[CTR_W-1:0].
REQ-023 Lookup SHALL be combinational with zero latency: hit = lookup_en_i & valid & tag match.
REQ-024 On a hit: pre_sel_o = 1, pre_take_or_not_o = ctr MSB, and pre_branch_flag_o = ctr MSB.
REQ-025 pre_branch_target_address_o SHALL equal the entry target on a hit and 0 otherwise.
REQ-026 All four prediction outputs SHALL be 0 on a miss, when lookup_en_i = 0, or while rst = 1.
REQ-027 Update SHALL occur on a clock edge with id_is_branch_i = 1, at the entry indexed by id_pc_i.
REQ-028 Update, tag match: ctr +1 saturating at all-ones when taken, -1 saturating at 0 when not taken; target written only when taken.
REQ-029 Update, tag miss or invalid entry, taken: allocate with valid = 1, new tag, target = id_target_i, ctr = weakly taken (MSB 1, other bits 0).
REQ-030 Update, tag miss, not taken: no table change.
REQ-031 branch_cnt_o SHALL increment on every update.
REQ-032 mispredict_cnt_o SHALL increment on an update when id_pre_true_i = 0.
REQ-033 Both counters SHALL saturate at 0xFFFFFFFF.
REQ-034 Same-cycle lookup and update to one index: lookup SHALL return the pre-update contents; the new value is visible the following cycle.
REQ-035 flush_i SHALL clear all valid bits in one cycle; counters and statistics SHALL be unaffected.
REQ-036 flush_i together with an update: flush wins, no allocation occurs, and statistics still count the update.
REQ-037 Allocation over a valid entry with a different tag SHALL overwrite it (direct-mapped replacement).

Reset
REQ-038 rst SHALL clear all valid bits, set every ctr to weakly not-taken (MSB 0, other bits 1), and zero both statistics counters.
REQ-039 rst SHALL override any same-cycle update or flush.
REQ-040 Tag and target arrays are not reset.
REQ-041 Reset asserted mid-stream SHALL give a miss on the first lookup after deassertion.

Structure
REQ-042 The shared definitions package SHALL hold the ctr weak-taken and weak-not-taken constants, the IDX/TAG derivation, and the 32-bit address width.
REQ-043 One sub-module, sat_counter (parametrised width, inc/dec/load), SHALL be instantiated for the direction update.
REQ-044 The table SHALL be register-based, not a RAM macro, so that the lookup is combinational.

Verification
REQ-045 After reset, lookup pc 0x100 -> pre_sel_o = 0, pre_branch_flag_o = 0, target = 0.
REQ-046 Update pc 0x100 taken, target 0x200; next cycle lookup 0x100 -> hit, flag = 1, target = 0x200, ctr = 2'b10.
REQ-047 Three further not-taken updates at 0x100 -> ctr goes 01, 00, 00 (saturates); lookup shows hit with flag = 0.
REQ-048 With ENTRIES = 64: allocate 0x100, then taken update at 0x200 (same index, different tag) -> lookup 0x100 misses and 0x200 hits.
REQ-049 Same-cycle lookup and allocate at 0x300 -> miss that cycle, hit the next; flush with a same-cycle update -> all entries miss, branch_cnt_o increments.
REQ-050 Five updates with id_pre_true_i = 0,1,0,0,1 -> branch_cnt_o = 5, mispredict_cnt_o = 3; a forced counter at 0xFFFFFFFF stays there.
